// File: rtl/data_mem.sv
// Word-organised data memory serving the MEM-stage DMEM request port.
// Byte-lane writes, one-clock registered reads with write-first merge, and a
// clear FSM that zeroes the array after reset or on a DMEM clear request.
// Optional feature macro: DMEM_PARITY_EN adds one even-parity bit per byte lane.
module data_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  DMEM_rst_i,
    input  logic [31:0]           DMEM_add_i,
    input  logic [3:0]            DMEM_byte_mark_i,
    input  logic [DATA_WIDTH-1:0] DMEM_data_i,
    input  logic                  DMEM_rd_i,
    output logic [DATA_WIDTH-1:0] DMEM_data_o,
    output logic                  DMEM_ready_o,
    output logic                  DMEM_err_o,
    output logic                  DMEM_perr_o
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned NLANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {StClear, StReady} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_perr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_oor;
    logic                  w_ready_st;
    logic                  w_wr_en;
    logic                  w_perr;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_unused;

    assign w_idx      = DMEM_add_i[ADDR_WIDTH+1:2];
    assign w_oor      = |DMEM_add_i[31:ADDR_WIDTH+2];
    assign w_ready_st = (r_state == StReady);
    // Out-of-range writes are dropped so they never alias onto a real word.
    assign w_wr_en    = w_ready_st && !w_oor && (DMEM_byte_mark_i != '0);
    assign w_old      = r_mem[w_idx];
    assign w_unused   = ^DMEM_add_i[1:0];

    // Write-first view of the addressed word: new lanes where marked, old elsewhere.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NLANES; i++) begin
            if (DMEM_byte_mark_i[i]) begin
                w_merged[8*i +: 8] = DMEM_data_i[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [NLANES-1:0] r_par [DEPTH];
    logic [NLANES-1:0] w_par_merged;
    logic [NLANES-1:0] w_par_calc;

    // Stored parity for untouched lanes, fresh parity for lanes being written.
    always_comb begin
        w_par_merged = r_par[w_idx];
        w_par_calc   = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (DMEM_byte_mark_i[i]) begin
                w_par_merged[i] = ^DMEM_data_i[8*i +: 8];
            end
            w_par_calc[i] = ^w_merged[8*i +: 8];
        end
    end

    assign w_perr = |(w_par_merged ^ w_par_calc);

    // Parity array follows the data array: zeroed on clear, updated on write.
    always_ff @(posedge clk) begin
        if (r_state == StClear) begin
            r_par[r_cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (w_wr_en) begin
            r_par[w_idx] <= w_par_merged;
        end
    end
`else
    assign w_perr = 1'b0;
`endif

    // Array storage; not reset, the clear FSM zeroes it instead.
    always_ff @(posedge clk) begin
        if (r_state == StClear) begin
            r_mem[r_cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Clear/ready FSM with registered read data, ready, error and parity flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT_ZERO ? StClear : StReady;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ready <= !INIT_ZERO;
            r_err   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_perr <= 1'b0;
            if (DMEM_rd_i) begin
                if (w_ready_st && !w_oor) begin
                    r_data <= w_merged;
                    r_perr <= w_perr;
                end else begin
                    r_data <= '0;
                end
            end
            if (w_ready_st && w_oor && (DMEM_rd_i || (DMEM_byte_mark_i != '0))) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                StClear: begin
                    if (DMEM_rst_i) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= StReady;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StReady: begin
                    // The access in this same cycle has already been handled above.
                    if (DMEM_rst_i) begin
                        r_state <= StClear;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= StClear;
            endcase
        end
    end

    assign DMEM_data_o  = r_data;
    assign DMEM_ready_o = r_ready;
    assign DMEM_err_o   = r_err;
    assign DMEM_perr_o  = r_perr;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem (ADDR_WIDTH=4): directed cases plus randomized traffic
// checked every cycle against a word-array reference model.
module tb_data_mem;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        DMEM_rst_i = 1'b0;
    logic [31:0] DMEM_add_i = '0;
    logic [3:0]  DMEM_byte_mark_i = '0;
    logic [31:0] DMEM_data_i = '0;
    logic        DMEM_rd_i = 1'b0;
    logic [31:0] DMEM_data_o;
    logic        DMEM_ready_o;
    logic        DMEM_err_o;
    logic        DMEM_perr_o;

    int vectors = 0;
    int miscompares = 0;

    data_mem #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(AW),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .DMEM_rst_i      (DMEM_rst_i),
        .DMEM_add_i      (DMEM_add_i),
        .DMEM_byte_mark_i(DMEM_byte_mark_i),
        .DMEM_data_i     (DMEM_data_i),
        .DMEM_rd_i       (DMEM_rd_i),
        .DMEM_data_o     (DMEM_data_o),
        .DMEM_ready_o    (DMEM_ready_o),
        .DMEM_err_o      (DMEM_err_o),
        .DMEM_perr_o     (DMEM_perr_o)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_mem [DEPTH];
    logic [3:0]  m_bad [DEPTH];   // lanes whose stored data was corrupted behind the parity
    bit          m_clearing = 1'b1;
    int          m_clr = 0;
    logic [31:0] exp_data = '0;
    logic        exp_ready = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_perr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b1;
        m_clr      = 0;
        exp_data   = '0;
        exp_ready  = 1'b0;
        exp_err    = 1'b0;
        exp_perr   = 1'b0;
    endtask

    always @(negedge rst_n) model_reset();

    // Model: advance one clock using the inputs seen at this edge.
    always @(posedge clk) begin
        logic        oor;
        int          idx;
        logic [31:0] merged;
        if (!rst_n) begin
            model_reset();
        end else if (m_clearing) begin
            m_mem[m_clr] = '0;
            m_bad[m_clr] = '0;
            if (DMEM_rd_i) exp_data = '0;
            exp_err  = 1'b0;
            exp_perr = 1'b0;
            if (DMEM_rst_i) begin
                m_clr = 0;
            end else if (m_clr == DEPTH - 1) begin
                m_clearing = 1'b0;
                exp_ready  = 1'b1;
            end else begin
                m_clr = m_clr + 1;
            end
        end else begin
            oor    = (DMEM_add_i >> (AW + 2)) != 0;
            idx    = int'(DMEM_add_i[AW+1:2]);
            merged = m_mem[idx];
            for (int b = 0; b < 4; b++) begin
                if (DMEM_byte_mark_i[b]) merged[8*b +: 8] = DMEM_data_i[8*b +: 8];
            end
            exp_err  = oor && (DMEM_rd_i || DMEM_byte_mark_i != 4'h0);
            exp_perr = DMEM_rd_i && !oor && ((m_bad[idx] & ~DMEM_byte_mark_i) != 4'h0);
            if (DMEM_rd_i) exp_data = oor ? 32'h0 : merged;
            if (!oor && DMEM_byte_mark_i != 4'h0) begin
                m_mem[idx] = merged;
                m_bad[idx] = m_bad[idx] & ~DMEM_byte_mark_i;
            end
            if (DMEM_rst_i) begin
                m_clearing = 1'b1;
                m_clr      = 0;
                exp_ready  = 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("data", DMEM_data_o, exp_data);
        chk("ready", 32'(DMEM_ready_o), 32'(exp_ready));
        chk("err", 32'(DMEM_err_o), 32'(exp_err));
        chk("perr", 32'(DMEM_perr_o), 32'(exp_perr));
    end

    // Drive one request for one edge; returns at edge+1.
    task automatic step(input logic rd, input logic [3:0] mk, input logic [31:0] a,
                        input logic [31:0] d, input logic crst);
        #1;
        DMEM_rd_i        = rd;
        DMEM_byte_mark_i = mk;
        DMEM_add_i       = a;
        DMEM_data_i      = d;
        DMEM_rst_i       = crst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Release reset and expect ready exactly 16 edges later.
    task automatic release_and_wait();
        #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            chk("ready_rise", 32'(DMEM_ready_o), (i == DEPTH - 1) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = '0;
        end
        @(posedge clk);
        #1;
        chk("reset_data", DMEM_data_o, 32'h0);
        chk("reset_ready", 32'(DMEM_ready_o), 32'h0);
        idle();
        release_and_wait();

        // Cleared array reads back zero.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b0);
            chk("clear_rd_data", DMEM_data_o, 32'h0);
            chk("clear_rd_err", 32'(DMEM_err_o), 32'h0);
        end

        // Partial lane update.
        step(1'b0, 4'hF, 32'h8, 32'hDEADBEEF, 1'b0);
        step(1'b0, 4'h2, 32'h8, 32'h0000AA00, 1'b0);
        step(1'b1, 4'h0, 32'h8, 32'h0, 1'b0);
        chk("lane_merge", DMEM_data_o, 32'hDEADAAEF);

        // Same-cycle read and write: write-first.
        step(1'b1, 4'hF, 32'h4, 32'h12345678, 1'b0);
        chk("write_first", DMEM_data_o, 32'h12345678);

        // Out-of-range access.
        step(1'b0, 4'hF, 32'h40, 32'hFFFFFFFF, 1'b0);
        chk("oor_wr_err", 32'(DMEM_err_o), 32'h1);
        step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
        chk("oor_rd_data", DMEM_data_o, 32'h0);
        chk("oor_rd_err", 32'(DMEM_err_o), 32'h1);
        idle();
        chk("oor_err_pulse", 32'(DMEM_err_o), 32'h0);
        step(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("no_alias", DMEM_data_o, 32'h0);

        // Parity: corrupt stored bit 0 of word 3 behind the parity bit.
        step(1'b0, 4'hF, 32'hC, 32'h000000A5, 1'b0);
`ifdef DMEM_PARITY_EN
        dut.r_mem[3] = dut.r_mem[3] ^ 32'h1;
        m_mem[3]     = m_mem[3] ^ 32'h1;
        m_bad[3]     = 4'h1;
        step(1'b1, 4'h0, 32'hC, 32'h0, 1'b0);
        chk("par_data", DMEM_data_o, 32'h000000A4);
        chk("par_perr", 32'(DMEM_perr_o), 32'h1);
`else
        step(1'b1, 4'h0, 32'hC, 32'h0, 1'b0);
        chk("par_data", DMEM_data_o, 32'h000000A5);
        chk("par_perr", 32'(DMEM_perr_o), 32'h0);
`endif

        // Fill the array, then request a clear.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 4'hF, 32'(i * 4), $urandom, 1'b0);
        end
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("clr_ready_drop", 32'(DMEM_ready_o), 32'h0);
        step(1'b1, 4'h0, 32'h14, 32'h0, 1'b0);
        chk("clr_rd_data", DMEM_data_o, 32'h0);
        chk("clr_rd_err", 32'(DMEM_err_o), 32'h0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            idle();
            chk("clr_ready", 32'(DMEM_ready_o), (i == DEPTH - 2) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b0);
            chk("post_clr_data", DMEM_data_o, 32'h0);
        end

        // Async reset mid-operation drops pending read data.
        step(1'b0, 4'hF, 32'h10, 32'hCAFEF00D, 1'b0);
        step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        chk("pre_rst_data", DMEM_data_o, 32'hCAFEF00D);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_data", DMEM_data_o, 32'h0);
        chk("async_rst_ready", 32'(DMEM_ready_o), 32'h0);
        @(posedge clk);
        #1;
        release_and_wait();

        // Randomized traffic, checked each cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [3:0]  mk;
            mk = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
            a  = ($urandom_range(0, 9) == 0) ? $urandom : {26'h0, 6'($urandom)};
            step(1'($urandom_range(0, 1)), mk, a, $urandom, ($urandom_range(0, 49) == 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
